ahb_reg_responder: RTL and testbench



---
 rtl/ahb_reg_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ahb_reg_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_reg_responder.sv
// -----------------------------------------------------------------------------
// ahb_reg_responder
//
// AHB-Lite responder for one bus-matrix output port: a bank of 32-bit
// registers with a programmable number of wait states on every OKAY data
// phase and the two-cycle ERROR response. Register 0 is a read-only ID word.
//
// Optional build feature (macro AHB_RESP_HRUSER_EN):
//   defined   : on a completing OKAY read, HRUSER = {24'b0, index[3:0],
//               P3..P0}, where Pn is the XOR (even parity) of HRDATA byte n.
//               HRUSER is 0 in every other cycle.
//   undefined : HRUSER is tied to zero and no parity logic is built.
//
// Parameters:
//   ADDR_WIDTH  : byte-address bits decoded; register index = HADDR[AW-1:2]
//   NUM_REGS    : implemented registers (1..2^(ADDR_WIDTH-2)), reg 0 = ID
//   WAIT_STATES : extra HREADYOUT-low cycles per OKAY data phase (0..15)
//   ID_VALUE    : constant returned by register 0
//
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY : address-phase inputs
//   HWDATA        : write data (data phase)
//   HREADYOUT     : slave ready (registered)
//   HRESP         : 2'b00 OKAY, 2'b01 ERROR (registered)
//   HRDATA        : read data, non-zero only in the completing read cycle
//   HRUSER        : read user data (see optional feature above)
//
// Handshake: an address phase is taken on a rising HCLK edge when
// HSEL & HREADY & HTRANS[1] and this responder is itself ready (HREADYOUT=1,
// i.e. the previous data phase completes in that same cycle). A data phase
// completes in the first cycle where HREADYOUT=1; write data is sampled and
// read data is presented only in that completing cycle.
// -----------------------------------------------------------------------------
module ahb_reg_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h0A5C_0001
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic [31:0]           HRUSER
);

    localparam int          IDX_W      = ADDR_WIDTH - 2;
    localparam int          RIW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dp_valid_q, dp_valid_d;   // OKAY data phase in flight
    logic              dp_write_q, dp_write_d;
    logic [RIW-1:0]    dp_idx_q, dp_idx_d;
    logic [3:0]        dp_be_q, dp_be_d;
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];
    logic              hreadyout_q, hreadyout_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [31:0]       hrdata_q, hrdata_d;

    // ---------------------------------------------------------------------
    // Address-phase decode
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0]  a_idx;
    logic              a_idx_oor;
    logic              a_size_err;
    logic              a_misalign;
    logic              a_ro_err;
    logic              a_err;
    logic [3:0]        a_be;
    logic              accept;

    // HTRANS[0] only separates NONSEQ from SEQ / IDLE from BUSY; both members
    // of each pair are handled identically here.
    logic              unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    always_comb begin
        a_idx      = HADDR[ADDR_WIDTH-1:2];
        a_idx_oor  = (32'(a_idx) >= NUM_REGS_U);
        a_size_err = (HSIZE > 3'b010);
        a_misalign = ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        a_ro_err   = HWRITE && (a_idx == '0);
        a_err      = a_idx_oor || a_size_err || a_misalign || a_ro_err;

        // Little-endian byte lanes. Sizes above a word are errors, so the
        // default lane pattern for them is never used for a write.
        unique case (HSIZE)
            3'b000:  a_be = 4'b0001 << HADDR[1:0];
            3'b001:  a_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase

        // hreadyout_q also gates acceptance so that a stray HREADY during our
        // own low cycles can never start a second transfer.
        accept = HSEL && HREADY && HTRANS[1] && hreadyout_q;
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    logic              wr_en;
    logic              rd_fire;
    logic [RIW-1:0]    rd_idx;
    logic [31:0]       rd_val;
`ifdef AHB_RESP_HRUSER_EN
    logic [31:0]       hruser_q, hruser_d;
    logic [3:0]        rd_par;
    logic [31:0]       rd_idx32;
`endif

    always_comb begin
        // Register bank: write in the completing cycle of an OKAY write.
        wr_en  = dp_valid_q && dp_write_q && hreadyout_q;
        regs_d = regs_q;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_be_q[b]) begin
                    regs_d[dp_idx_q][8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
        regs_d[0] = ID_VALUE;

        // FSM
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (a_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // Data-phase controls are replaced whenever the current data phase
        // completes (hreadyout_q=1); during low cycles they are held.
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_be_d    = dp_be_q;
        if (hreadyout_q) begin
            dp_valid_d = accept && !a_err;
            if (accept) begin
                dp_write_d = HWRITE;
                dp_idx_d   = a_idx[RIW-1:0];
                dp_be_d    = a_be;
            end
        end

        // Read data is registered one edge ahead of the completing cycle.
        // It is taken from regs_d so a write completing on that same edge is
        // forwarded into a back-to-back read of the same register.
        rd_fire = 1'b0;
        rd_idx  = dp_idx_q;
        if ((WAIT_STATES == 0) && accept && !a_err && !HWRITE) begin
            rd_fire = 1'b1;
            rd_idx  = a_idx[RIW-1:0];
        end
        if ((state_q == ST_WAIT) && (cnt_q == 4'd0) && dp_valid_q && !dp_write_q) begin
            rd_fire = 1'b1;
        end
        rd_val = regs_d[rd_idx];

        // Registered bus outputs derived from the next state.
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
        hrdata_d    = rd_fire ? rd_val : 32'h0;

`ifdef AHB_RESP_HRUSER_EN
        for (int b = 0; b < 4; b++) begin
            rd_par[b] = ^rd_val[8*b +: 8];
        end
        rd_idx32 = 32'(rd_idx);
        hruser_d = rd_fire ? {24'h0, rd_idx32[3:0], rd_par} : 32'h0;
`endif
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= '0;
            dp_be_q     <= 4'b0000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 32'h0;
            end
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= 32'h0;
`ifdef AHB_RESP_HRUSER_EN
            hruser_q    <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_idx_q    <= dp_idx_d;
            dp_be_q     <= dp_be_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
`ifdef AHB_RESP_HRUSER_EN
            hruser_q    <= hruser_d;
`endif
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
`ifdef AHB_RESP_HRUSER_EN
    assign HRUSER    = hruser_q;
`else
    assign HRUSER    = 32'h0;
`endif

endmodule

// File: tb/tb_ahb_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_ahb_reg_responder
//
// Directed bench for ahb_reg_responder. Two instances share the address and
// write-data bus: dut0 with zero wait states and dut3 with three. Each
// instance's HREADY is its own HREADYOUT, as seen by a single-slave master.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_ahb_reg_responder;

    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;
    localparam logic [1:0]  T_SEQ    = 2'b11;
    localparam logic [31:0] ID_WORD  = 32'h0A5C_0001;

    // clock / reset
    logic        hclk = 1'b0;
    logic        hresetn;
    always #5 hclk = ~hclk;

    // shared bus
    logic        sel0, sel3;
    logic [9:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        rdy0, rdy3;
    logic [1:0]  rsp0, rsp3;
    logic [31:0] rd0, rd3, ru0, ru3;

    logic        use3;
    logic        cur_rdy;
    logic [1:0]  cur_rsp;
    logic [31:0] cur_rd, cur_ru;
    assign cur_rdy = use3 ? rdy3 : rdy0;
    assign cur_rsp = use3 ? rsp3 : rsp0;
    assign cur_rd  = use3 ? rd3  : rd0;
    assign cur_ru  = use3 ? ru3  : ru0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_ru_raw;
    logic [31:0] exp_ru_par;

    ahb_reg_responder #(
        .ADDR_WIDTH (10),
        .NUM_REGS   (16),
        .WAIT_STATES(0),
        .ID_VALUE   (ID_WORD)
    ) dut0 (
        .HCLK     (hclk),
        .HRESETn  (hresetn),
        .HSEL     (sel0),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (rdy0),
        .HREADYOUT(rdy0),
        .HRESP    (rsp0),
        .HRDATA   (rd0),
        .HRUSER   (ru0)
    );

    ahb_reg_responder #(
        .ADDR_WIDTH (10),
        .NUM_REGS   (16),
        .WAIT_STATES(3),
        .ID_VALUE   (ID_WORD)
    ) dut3 (
        .HCLK     (hclk),
        .HRESETn  (hresetn),
        .HSEL     (sel3),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (rdy3),
        .HREADYOUT(rdy3),
        .HRESP    (rsp3),
        .HRDATA   (rd3),
        .HRUSER   (ru3)
    );

    // ---------------------------------------------------------------------
    // driver / checker tasks
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic [9:0] a, input logic [1:0] t,
                           input logic w, input logic [2:0] s);
        haddr  = a;
        htrans = t;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle_ph();
        htrans = T_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Samples the selected responder on the next falling edge.
    task automatic chk_bus(input string tag, input logic rdy, input logic [1:0] rsp,
                           input logic [31:0] dat);
        @(negedge hclk);
        chk({tag, ".hreadyout"}, {31'h0, cur_rdy}, {31'h0, rdy});
        chk({tag, ".hresp"},     {30'h0, cur_rsp}, {30'h0, rsp});
        chk({tag, ".hrdata"},    cur_rd, dat);
    endtask

    // ---------------------------------------------------------------------
    // directed sequence
    // ---------------------------------------------------------------------
    initial begin
`ifdef AHB_RESP_HRUSER_EN
        // 0x1234BEEF from index 1: byte parities P3..P0 = ^12,^34,^BE,^EF
        // = 0,1,0,1 -> {4'h1, 4'b0101}.
        exp_ru_raw = 32'h0000_0015;
        // 0x01FF0003 from index 3: P3..P0 = ^01,^FF,^00,^03 = 1,0,0,0.
        exp_ru_par = 32'h0000_0038;
`else
        exp_ru_raw = 32'h0;
        exp_ru_par = 32'h0;
`endif
        hresetn = 1'b0;
        sel0    = 1'b1;
        sel3    = 1'b0;
        use3    = 1'b0;
        haddr   = 10'h000;
        hsize   = 3'b010;
        hwdata  = 32'h0;
        idle_ph();

        // reset values on both instances
        @(negedge hclk);
        chk("rst0.hreadyout", {31'h0, rdy0}, 32'h1);
        chk("rst0.hresp",     {30'h0, rsp0}, 32'h0);
        chk("rst0.hrdata",    rd0, 32'h0);
        chk("rst0.hruser",    ru0, 32'h0);
        chk("rst3.hreadyout", {31'h0, rdy3}, 32'h1);
        chk("rst3.hresp",     {30'h0, rsp3}, 32'h0);
        tick();
        hresetn = 1'b1;

        // ID read, zero wait: data in the very next cycle, gone after
        addr_ph(10'h000, T_NONSEQ, 1'b0, 3'b010);
        tick();
        idle_ph();
        chk_bus("id_rd", 1'b1, 2'b00, ID_WORD);
        tick();
        chk_bus("id_after", 1'b1, 2'b00, 32'h0);
        tick();

        // word write, halfword write to upper lanes, read back: no bubbles
        addr_ph(10'h004, T_NONSEQ, 1'b1, 3'b010);
        tick();
        hwdata = 32'hDEAD_BEEF;
        addr_ph(10'h006, T_NONSEQ, 1'b1, 3'b001);
        chk_bus("w_word_dp", 1'b1, 2'b00, 32'h0);
        tick();
        hwdata = 32'h1234_5678;
        addr_ph(10'h004, T_NONSEQ, 1'b0, 3'b010);
        chk_bus("w_half_dp", 1'b1, 2'b00, 32'h0);
        tick();
        hwdata = 32'h0;
        idle_ph();
        chk_bus("raw_rd", 1'b1, 2'b00, 32'h1234_BEEF);
        chk("raw_rd.hruser", cur_ru, exp_ru_raw);
        tick();

        // byte write to lane 1 of register 2, only that lane changes
        addr_ph(10'h009, T_NONSEQ, 1'b1, 3'b000);
        tick();
        hwdata = 32'hFFFF_A5FF;
        addr_ph(10'h008, T_NONSEQ, 1'b0, 3'b010);
        chk_bus("w_byte_dp", 1'b1, 2'b00, 32'h0);
        tick();
        hwdata = 32'h0;
        idle_ph();
        chk_bus("byte_rd", 1'b1, 2'b00, 32'h0000_A500);
        tick();

        // write to ID register, then out-of-range read: two ERROR responses
        addr_ph(10'h000, T_NONSEQ, 1'b1, 3'b010);
        tick();
        hwdata = 32'hFFFF_FFFF;
        addr_ph(10'h040, T_NONSEQ, 1'b0, 3'b010);
        chk_bus("ro_err1", 1'b0, 2'b01, 32'h0);
        tick();
        chk_bus("ro_err2", 1'b1, 2'b01, 32'h0);
        tick();
        hwdata = 32'h0;
        idle_ph();
        chk_bus("oor_err1", 1'b0, 2'b01, 32'h0);
        tick();
        chk_bus("oor_err2", 1'b1, 2'b01, 32'h0);
        tick();
        addr_ph(10'h000, T_NONSEQ, 1'b0, 3'b010);
        chk_bus("err_done", 1'b1, 2'b00, 32'h0);
        tick();
        idle_ph();
        chk_bus("id_kept", 1'b1, 2'b00, ID_WORD);
        tick();

        // oversized transfer
        addr_ph(10'h010, T_NONSEQ, 1'b0, 3'b011);
        tick();
        idle_ph();
        chk_bus("size_err1", 1'b0, 2'b01, 32'h0);
        tick();
        chk_bus("size_err2", 1'b1, 2'b01, 32'h0);
        tick();

        // misaligned word read, master goes IDLE during ERR1
        addr_ph(10'h00A, T_NONSEQ, 1'b0, 3'b010);
        tick();
        idle_ph();
        chk_bus("mis_err1", 1'b0, 2'b01, 32'h0);
        tick();
        chk_bus("mis_err2", 1'b1, 2'b01, 32'h0);
        tick();
        chk_bus("mis_okay", 1'b1, 2'b00, 32'h0);
        tick();

        // HRUSER parity pattern
        addr_ph(10'h00C, T_NONSEQ, 1'b1, 3'b010);
        tick();
        hwdata = 32'h01FF_0003;
        addr_ph(10'h00C, T_NONSEQ, 1'b0, 3'b010);
        chk_bus("par_w_dp", 1'b1, 2'b00, 32'h0);
        tick();
        hwdata = 32'h0;
        idle_ph();
        chk_bus("par_rd", 1'b1, 2'b00, 32'h01FF_0003);
        chk("par_rd.hruser", cur_ru, exp_ru_par);
        tick();

        // ---- three wait states ----
        sel0 = 1'b0;
        sel3 = 1'b1;
        use3 = 1'b1;

        addr_ph(10'h008, T_NONSEQ, 1'b1, 3'b010);
        tick();
        hwdata = 32'hCAFE_F00D;
        addr_ph(10'h008, T_NONSEQ, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            chk_bus("ws_w_wait", 1'b0, 2'b00, 32'h0);
            tick();
        end
        chk_bus("ws_w_done", 1'b1, 2'b00, 32'h0);
        tick();
        hwdata = 32'h0;
        addr_ph(10'h000, T_SEQ, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            chk_bus("ws_r_wait", 1'b0, 2'b00, 32'h0);
            tick();
        end
        chk_bus("ws_r_done", 1'b1, 2'b00, 32'hCAFE_F00D);
        tick();
        idle_ph();
        for (int i = 0; i < 3; i++) begin
            chk_bus("seq_wait", 1'b0, 2'b00, 32'h0);
            tick();
        end
        chk_bus("seq_done", 1'b1, 2'b00, ID_WORD);
        tick();
        chk_bus("ws_idle", 1'b1, 2'b00, 32'h0);
        tick();

        // reset pulsed in the middle of a waited read
        addr_ph(10'h008, T_NONSEQ, 1'b0, 3'b010);
        tick();
        idle_ph();
        chk_bus("rst_wait", 1'b0, 2'b00, 32'h0);
        #1;
        hresetn = 1'b0;
        #1;
        chk("rst_mid.hreadyout", {31'h0, cur_rdy}, 32'h1);
        chk("rst_mid.hresp",     {30'h0, cur_rsp}, 32'h0);
        tick();
        hresetn = 1'b1;

        // register 2 was cleared by the reset
        addr_ph(10'h008, T_NONSEQ, 1'b0, 3'b010);
        tick();
        idle_ph();
        for (int i = 0; i < 3; i++) begin
            chk_bus("clr_wait", 1'b0, 2'b00, 32'h0);
            tick();
        end
        chk_bus("clr_rd", 1'b1, 2'b00, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
